// File: rtl/vc_buffer_pkg.sv
// vc_buffer_pkg
// Shared defaults and helper functions for the virtual-channel input buffer.
//   DEFAULT_*       : default parameter values for vc_input_buffer
//   vc_idx_width(n) : width of a channel index for n channels (at least 1)
//   ptr_wrap(p, d)  : next value of a circular pointer over 0..d-1
package vc_buffer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 5;
  localparam int DEFAULT_NUM_VC     = 2;

  function automatic int vc_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Depth need not be a power of two, so wrap explicitly instead of
  // relying on natural pointer overflow.
  function automatic int ptr_wrap(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl
// Pointer, occupancy and flag tracking for one virtual channel. Storage is
// held by the parent; this block only decides what is accepted and where.
//   clk, reset   : clock, synchronous active-low reset
//   wr_req       : a write is addressed to this channel
//   rd_req       : a read is addressed to this channel
//   wr_ptr       : slot the next accepted write lands in
//   rd_ptr       : slot the next accepted read pops
//   count        : occupancy 0..DEPTH
//   full, empty  : decoded from the registered count
//   wr_accept    : write accepted this cycle
//   rd_accept    : read accepted this cycle
//   overflow     : sticky, write seen while full
//   underflow    : sticky, read seen while empty
module vc_fifo_ctrl
  import vc_buffer_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_req,
  input  logic                 rd_req,
  output logic [CNT_WIDTH-1:0] wr_ptr,
  output logic [CNT_WIDTH-1:0] rd_ptr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty,
  output logic                 wr_accept,
  output logic                 rd_accept,
  output logic                 overflow,
  output logic                 underflow
);

  // Pointers share the count width; it always covers 0..DEPTH-1.
  logic [CNT_WIDTH-1:0] wr_ptr_reg;
  logic [CNT_WIDTH-1:0] rd_ptr_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 overflow_reg;
  logic                 underflow_reg;

  assign full      = (count_reg == CNT_WIDTH'(DEPTH));
  assign empty     = (count_reg == '0);
  assign wr_accept = wr_req && !full;
  assign rd_accept = rd_req && !empty;

  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CNT_WIDTH'(1);
      2'b01:   count_next = count_reg - CNT_WIDTH'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (wr_accept) begin
        wr_ptr_reg <= CNT_WIDTH'(ptr_wrap(int'(wr_ptr_reg), DEPTH));
      end
      if (rd_accept) begin
        rd_ptr_reg <= CNT_WIDTH'(ptr_wrap(int'(rd_ptr_reg), DEPTH));
      end
      if (wr_req && full) begin
        overflow_reg <= 1'b1;
      end
      if (rd_req && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign wr_ptr    = wr_ptr_reg;
  assign rd_ptr    = rd_ptr_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: rtl/vc_input_buffer.sv
// vc_input_buffer
// NUM_VC circular FIFOs sharing one flop storage array, with a registered
// read port and sticky per-channel overflow/underflow flags.
//   clk, reset           : clock, synchronous active-low reset
//   wr_valid_i/wr_vc_i/wr_data_i : write request, channel, data
//   rd_en_i/rd_vc_i      : read request, channel
//   rd_data_o/rd_valid_o : popped flit, valid one cycle after the request
//   empty_o/full_o       : per-channel status from registered counts
//   count_o              : per-channel occupancy, CNT_WIDTH bits each
//   overflow_o/underflow_o : sticky per-channel error flags
module vc_input_buffer
  import vc_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int NUM_VC     = DEFAULT_NUM_VC,
  parameter int VC_WIDTH   = vc_idx_width(NUM_VC),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid_i,
  input  logic [VC_WIDTH-1:0]         wr_vc_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic                        rd_en_i,
  input  logic [VC_WIDTH-1:0]         rd_vc_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o,
  output logic                        rd_valid_o,
  output logic [NUM_VC-1:0]           empty_o,
  output logic [NUM_VC-1:0]           full_o,
  output logic [NUM_VC*CNT_WIDTH-1:0] count_o,
  output logic [NUM_VC-1:0]           overflow_o,
  output logic [NUM_VC-1:0]           underflow_o
);

  localparam int WORDS      = NUM_VC * DEPTH;
  localparam int ADDR_WIDTH = (WORDS <= 1) ? 1 : $clog2(WORDS);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [CNT_WIDTH-1:0]  wr_ptr [NUM_VC];
  logic [CNT_WIDTH-1:0]  rd_ptr [NUM_VC];
  logic [CNT_WIDTH-1:0]  count  [NUM_VC];
  logic [NUM_VC-1:0]     wr_req;
  logic [NUM_VC-1:0]     rd_req;
  logic [NUM_VC-1:0]     wr_accept;
  logic [NUM_VC-1:0]     rd_accept;

  logic [CNT_WIDTH-1:0]  wr_ptr_sel;
  logic [CNT_WIDTH-1:0]  rd_ptr_sel;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_any;
  logic                  rd_any;

  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;

  // Channel decode by equality: an index >= NUM_VC matches no channel, so
  // such a request is dropped without touching any flag.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign wr_req[gi] = wr_valid_i && (wr_vc_i == VC_WIDTH'(gi));
      assign rd_req[gi] = rd_en_i    && (rd_vc_i == VC_WIDTH'(gi));

      vc_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
      ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req[gi]),
        .rd_req    (rd_req[gi]),
        .wr_ptr    (wr_ptr[gi]),
        .rd_ptr    (rd_ptr[gi]),
        .count     (count[gi]),
        .full      (full_o[gi]),
        .empty     (empty_o[gi]),
        .wr_accept (wr_accept[gi]),
        .rd_accept (rd_accept[gi]),
        .overflow  (overflow_o[gi]),
        .underflow (underflow_o[gi])
      );

      assign count_o[gi*CNT_WIDTH +: CNT_WIDTH] = count[gi];
    end
  endgenerate

  assign wr_any = |wr_accept;
  assign rd_any = |rd_accept;

  // Pointer select for the addressed channel, then flat address
  // vc*DEPTH + slot into the shared array.
  always_comb begin
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_vc_i == VC_WIDTH'(v)) wr_ptr_sel = wr_ptr[v];
      if (rd_vc_i == VC_WIDTH'(v)) rd_ptr_sel = rd_ptr[v];
    end
    wr_addr = ADDR_WIDTH'(int'(wr_vc_i) * DEPTH + int'(wr_ptr_sel));
    rd_addr = ADDR_WIDTH'(int'(rd_vc_i) * DEPTH + int'(rd_ptr_sel));
  end

  // Storage is not reset; writes are held off while reset is asserted so a
  // same-cycle request leaves no trace.
  always_ff @(posedge clk) begin
    if (reset && wr_any) begin
      mem[wr_addr] <= wr_data_i;
    end
  end

  // Registered read port; data holds when nothing is popped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_any;
      if (rd_any) begin
        rd_data_reg <= mem[rd_addr];
      end
    end
  end

  assign rd_data_o  = rd_data_reg;
  assign rd_valid_o = rd_valid_reg;

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer
// Directed tests for vc_input_buffer at default parameters (16-bit data,
// depth 5, two channels). Inputs change 1 time unit after each rising edge;
// outputs are inspected at that same point.
module tb_vc_input_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid_i;
  logic [0:0]  wr_vc_i;
  logic [15:0] wr_data_i;
  logic        rd_en_i;
  logic [0:0]  rd_vc_i;
  logic [15:0] rd_data_o;
  logic        rd_valid_o;
  logic [1:0]  empty_o;
  logic [1:0]  full_o;
  logic [5:0]  count_o;
  logic [1:0]  overflow_o;
  logic [1:0]  underflow_o;

  int passed = 0;
  int total  = 0;

  vc_input_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid_i  (wr_valid_i),
    .wr_vc_i     (wr_vc_i),
    .wr_data_i   (wr_data_i),
    .rd_en_i     (rd_en_i),
    .rd_vc_i     (rd_vc_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk = ~clk;

  wire [2:0] cnt0 = count_o[2:0];
  wire [2:0] cnt1 = count_o[5:3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid_i = 1'b0; wr_vc_i = '0; wr_data_i = '0;
    rd_en_i = 1'b0; rd_vc_i = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wr(input logic [0:0] vc, input logic [15:0] d);
    idle();
    wr_valid_i = 1'b1; wr_vc_i = vc; wr_data_i = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [0:0] vc);
    idle();
    rd_en_i = 1'b1; rd_vc_i = vc;
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    total++; if (empty_o !== 2'b11) $display("FAIL reset_empty got=%b exp=11", empty_o); else passed++;
    total++; if (full_o !== 2'b00) $display("FAIL reset_full got=%b exp=00", full_o); else passed++;
    total++; if (count_o !== 6'd0) $display("FAIL reset_count got=%h exp=0", count_o); else passed++;
    total++; if (rd_valid_o !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid_o); else passed++;
    total++; if (rd_data_o !== 16'h0) $display("FAIL reset_rd_data got=%h exp=0", rd_data_o); else passed++;
    total++; if ({overflow_o, underflow_o} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {overflow_o, underflow_o}); else passed++;
    $display("test_reset: empty=%b full=%b count=%h", empty_o, full_o, count_o);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 5; i++) begin
      wr(1'b0, 16'(i));
      total++; if (cnt0 !== 3'(i)) $display("FAIL fill_count%0d got=%0d exp=%0d", i, cnt0, i); else passed++;
      $display("fill: wrote %h count0=%0d full=%b", 16'(i), cnt0, full_o);
    end
    total++; if (full_o !== 2'b01) $display("FAIL fill_full got=%b exp=01", full_o); else passed++;
    for (int i = 1; i <= 5; i++) begin
      rd(1'b0);
      total++; if (rd_valid_o !== 1'b1 || rd_data_o !== 16'(i))
        $display("FAIL drain_data%0d got=%b/%h exp=1/%h", i, rd_valid_o, rd_data_o, 16'(i)); else passed++;
      $display("drain: read %h valid=%b count0=%0d", rd_data_o, rd_valid_o, cnt0);
    end
    tick();
    total++; if (rd_valid_o !== 1'b0) $display("FAIL drain_idle_valid got=%b exp=0", rd_valid_o); else passed++;
    total++; if (empty_o !== 2'b11 || count_o !== 6'd0)
      $display("FAIL drain_end got=%b/%h exp=11/0", empty_o, count_o); else passed++;
    total++; if (rd_data_o !== 16'h0005) $display("FAIL drain_hold got=%h exp=0005", rd_data_o); else passed++;
  endtask

  // Pointers start at 0 after the previous fill/drain; 7 writes carry the
  // write pointer through slot 4 back to slot 0.
  task automatic test_wrap();
    logic [13:0] ops;
    int exp_cnt [14] = '{1, 2, 1, 2, 3, 2, 3, 4, 3, 4, 3, 2, 1, 0};
    int wi = 0;
    int ri = 0;
    ops = 14'b11011011010000; // MSB first: 1 = write, 0 = read
    for (int s = 0; s < 14; s++) begin
      if (ops[13-s]) begin
        wr(1'b0, 16'h0010 + 16'(wi));
        wi++;
        total++; if (rd_valid_o !== 1'b0) $display("FAIL wrap_wr_valid s%0d got=%b exp=0", s, rd_valid_o); else passed++;
      end else begin
        rd(1'b0);
        total++; if (rd_valid_o !== 1'b1 || rd_data_o !== 16'h0010 + 16'(ri))
          $display("FAIL wrap_rd s%0d got=%b/%h exp=1/%h", s, rd_valid_o, rd_data_o, 16'h0010 + 16'(ri)); else passed++;
        ri++;
      end
      total++; if (cnt0 !== 3'(exp_cnt[s])) $display("FAIL wrap_count s%0d got=%0d exp=%0d", s, cnt0, exp_cnt[s]); else passed++;
      $display("wrap: step %0d op=%s count0=%0d data=%h", s, ops[13-s] ? "wr" : "rd", cnt0, rd_data_o);
    end
  endtask

  task automatic test_overflow_underflow();
    do_reset();
    for (int i = 1; i <= 5; i++) wr(1'b0, 16'h0020 + 16'(i));
    wr(1'b0, 16'hBEEF);
    $display("overflow: wrote beef to full vc0, ovf=%b count0=%0d", overflow_o, cnt0);
    total++; if (overflow_o !== 2'b01) $display("FAIL ovf_flag got=%b exp=01", overflow_o); else passed++;
    total++; if (cnt0 !== 3'd5 || full_o !== 2'b01) $display("FAIL ovf_count got=%0d/%b exp=5/01", cnt0, full_o); else passed++;
    for (int i = 1; i <= 5; i++) begin
      rd(1'b0);
      total++; if (rd_data_o !== 16'h0020 + 16'(i))
        $display("FAIL ovf_drain%0d got=%h exp=%h", i, rd_data_o, 16'h0020 + 16'(i)); else passed++;
      $display("overflow: read %h", rd_data_o);
    end
    rd(1'b1);
    $display("underflow: read empty vc1, unf=%b valid=%b", underflow_o, rd_valid_o);
    total++; if (underflow_o !== 2'b10) $display("FAIL unf_flag got=%b exp=10", underflow_o); else passed++;
    total++; if (rd_valid_o !== 1'b0) $display("FAIL unf_valid got=%b exp=0", rd_valid_o); else passed++;
    total++; if (overflow_o !== 2'b01) $display("FAIL ovf_sticky got=%b exp=01", overflow_o); else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    // Empty VC1: write wins, read underflows.
    idle();
    wr_valid_i = 1'b1; wr_vc_i = 1'b1; wr_data_i = 16'h0031;
    rd_en_i = 1'b1; rd_vc_i = 1'b1;
    tick(); idle();
    $display("simul empty: count1=%0d valid=%b unf=%b", cnt1, rd_valid_o, underflow_o);
    total++; if (cnt1 !== 3'd1 || rd_valid_o !== 1'b0 || underflow_o !== 2'b10)
      $display("FAIL simul_empty got=%0d/%b/%b exp=1/0/10", cnt1, rd_valid_o, underflow_o); else passed++;
    rd(1'b1);
    total++; if (rd_data_o !== 16'h0031 || cnt1 !== 3'd0) $display("FAIL simul_empty_rd got=%h/%0d exp=0031/0", rd_data_o, cnt1); else passed++;
    // Full VC0: read wins, write overflows.
    for (int i = 1; i <= 5; i++) wr(1'b0, 16'h0040 + 16'(i));
    idle();
    wr_valid_i = 1'b1; wr_vc_i = 1'b0; wr_data_i = 16'h004F;
    rd_en_i = 1'b1; rd_vc_i = 1'b0;
    tick(); idle();
    $display("simul full: count0=%0d data=%h ovf=%b", cnt0, rd_data_o, overflow_o);
    total++; if (cnt0 !== 3'd4 || rd_data_o !== 16'h0041 || rd_valid_o !== 1'b1 || overflow_o !== 2'b01)
      $display("FAIL simul_full got=%0d/%h/%b/%b exp=4/0041/1/01", cnt0, rd_data_o, rd_valid_o, overflow_o); else passed++;
    // VC0 at count 2: both accepted, count holds.
    rd(1'b0); rd(1'b0);
    total++; if (rd_data_o !== 16'h0043 || cnt0 !== 3'd2) $display("FAIL simul_pre got=%h/%0d exp=0043/2", rd_data_o, cnt0); else passed++;
    idle();
    wr_valid_i = 1'b1; wr_vc_i = 1'b0; wr_data_i = 16'h0046;
    rd_en_i = 1'b1; rd_vc_i = 1'b0;
    tick(); idle();
    $display("simul mid: count0=%0d data=%h", cnt0, rd_data_o);
    total++; if (cnt0 !== 3'd2 || rd_data_o !== 16'h0044) $display("FAIL simul_mid got=%0d/%h exp=2/0044", cnt0, rd_data_o); else passed++;
    // Different channels: read VC0 while writing VC1.
    idle();
    wr_valid_i = 1'b1; wr_vc_i = 1'b1; wr_data_i = 16'h0051;
    rd_en_i = 1'b1; rd_vc_i = 1'b0;
    tick(); idle();
    $display("simul diff: count0=%0d count1=%0d data=%h", cnt0, cnt1, rd_data_o);
    total++; if (cnt0 !== 3'd1 || cnt1 !== 3'd1 || rd_data_o !== 16'h0045)
      $display("FAIL simul_diff got=%0d/%0d/%h exp=1/1/0045", cnt0, cnt1, rd_data_o); else passed++;
    rd(1'b0);
    total++; if (rd_data_o !== 16'h0046) $display("FAIL simul_tail0 got=%h exp=0046", rd_data_o); else passed++;
    rd(1'b1);
    total++; if (rd_data_o !== 16'h0051 || empty_o !== 2'b11) $display("FAIL simul_tail1 got=%h/%b exp=0051/11", rd_data_o, empty_o); else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr(1'b0, 16'h0061); wr(1'b0, 16'h0062); wr(1'b0, 16'h0063);
    rd(1'b0);
    wr(1'b0, 16'h0064);
    rd(1'b1); // sets underflow[1] so reset has a flag to clear
    total++; if (cnt0 !== 3'd3 || rd_data_o !== 16'h0061 || underflow_o !== 2'b10)
      $display("FAIL midrst_pre got=%0d/%h/%b exp=3/0061/10", cnt0, rd_data_o, underflow_o); else passed++;
    idle();
    reset = 1'b0;
    wr_valid_i = 1'b1; wr_vc_i = 1'b0; wr_data_i = 16'h0065;
    tick();
    reset = 1'b1; idle();
    $display("mid reset: empty=%b count=%h data=%h flags=%b", empty_o, count_o, rd_data_o, {overflow_o, underflow_o});
    total++; if (empty_o !== 2'b11 || full_o !== 2'b00 || count_o !== 6'd0)
      $display("FAIL midrst_status got=%b/%b/%h exp=11/00/0", empty_o, full_o, count_o); else passed++;
    total++; if (rd_data_o !== 16'h0 || rd_valid_o !== 1'b0 || {overflow_o, underflow_o} !== 4'b0)
      $display("FAIL midrst_out got=%h/%b/%b exp=0/0/0000", rd_data_o, rd_valid_o, {overflow_o, underflow_o}); else passed++;
    rd(1'b0);
    total++; if (rd_valid_o !== 1'b0 || underflow_o !== 2'b01 || cnt0 !== 3'd0)
      $display("FAIL midrst_discard got=%b/%b/%0d exp=0/01/0", rd_valid_o, underflow_o, cnt0); else passed++;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_overflow_underflow();
    test_simultaneous();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
# vc_input_buffer

Parametrised multi-channel input buffer that generalises the single-bank flop RAM into `NUM_VC` independent circular FIFOs sharing one flop storage array. It adds per-channel pointer and occupancy tracking, full/empty flow control, a registered read port, and sticky overflow/underflow flags. It sits at each router input port between the link receiver (write side) and the switch allocator/crossbar (read side).

## Interface
- `DATA_WIDTH`, 16, flit width in bits
- `DEPTH`, 5, entries per virtual channel; ≥2, need not be a power of two
- `NUM_VC`, 2, number of virtual channels; ≥1
- `VC_WIDTH`, derived = max(1, $clog2(NUM_VC)), channel index width
- `CNT_WIDTH`, derived = $clog2(DEPTH+1), occupancy width
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `wr_valid_i`  in  1  write request
- `wr_vc_i`  in  VC_WIDTH  target channel of write
- `wr_data_i`  in  DATA_WIDTH  write data
- `rd_en_i`  in  1  read request
- `rd_vc_i`  in  VC_WIDTH  source channel of read
- `rd_data_o`  out  DATA_WIDTH  registered read data
- `rd_valid_o`  out  1  `rd_data_o` holds a freshly popped flit
- `empty_o`  out  NUM_VC  per-channel empty
- `full_o`  out  NUM_VC  per-channel full
- `count_o`  out  NUM_VC*CNT_WIDTH  per-channel occupancy; channel v in bits [v*CNT_WIDTH +: CNT_WIDTH]
- `overflow_o`  out  NUM_VC  sticky: write attempted to a full channel
- `underflow_o`  out  NUM_VC  sticky: read attempted from an empty channel

## Operation
- Storage: NUM_VC*DEPTH words; channel v, slot p at address v*DEPTH + p. Storage contents are not reset.
- Each channel keeps a write pointer, a read pointer (0..DEPTH-1), and a count (0..DEPTH).
- Write accepted iff `wr_valid_i` && !`full_o[wr_vc_i]`. On accept: word stored at the write pointer; the pointer advances and wraps from DEPTH-1 to 0; count +1.
- Write to a full channel: dropped, storage and pointers unchanged, `overflow_o[wr_vc_i]` set.
- Read accepted iff `rd_en_i` && !`empty_o[rd_vc_i]`. On accept: the word at the read pointer is loaded into `rd_data_o`, `rd_valid_o`=1 next cycle, the pointer advances with the same wrap rule, count −1.
- Read from an empty channel: ignored, `rd_valid_o`=0 next cycle, `underflow_o[rd_vc_i]` set.
- `rd_data_o` holds its last value when no read is accepted.
- `full_o`/`empty_o` decode the registered count only (count==DEPTH / count==0). There is no fall-through or bypass path.
- Simultaneous write and read, same channel, neither full nor empty: both accepted, count unchanged.
- Simultaneous write and read, same channel, empty: write accepted, read rejected with underflow.
- Simultaneous write and read, same channel, full: read accepted, write rejected with overflow.
- Simultaneous write and read, different channels: fully independent.
- `wr_vc_i`/`rd_vc_i` ≥ NUM_VC: the request is ignored, no flag is set.
- Sticky flags clear only on reset.

## Timing
- Reset (sampled low at the edge) values: all pointers and counts 0, `empty_o` all 1, `full_o` 0, `count_o` 0, `rd_valid_o` 0, `rd_data_o` 0, `overflow_o`/`underflow_o` 0. Reset overrides any same-cycle request. Mid-operation reset discards all buffered data.
- Write-to-read latency: data written at edge N is readable by a request presented in the cycle after edge N. `rd_data_o` is valid after edge N+1.
- Read latency: 1 cycle, request at edge N gives `rd_data_o`/`rd_valid_o` after edge N.
- `full_o`, `empty_o`, `count_o` update at the same edge as the accepted operation.
- Flags assert at the edge that samples the illegal request.

## Structure
- Package `vc_buffer_pkg`: default parameter values, a `vc_idx_width(n)` function, and a `ptr_wrap(ptr, depth)` function.
- Sub-module `vc_fifo_ctrl` (params `DEPTH`, `CNT_WIDTH`): one channel's pointers, count, full/empty, and flags. Instantiated NUM_VC times by generate.
- Top level holds the storage array, address generation, write-enable decode, read mux, and output register.

## Test plan
- Reset then idle → `empty_o`=2'b11, `full_o`=0, counts 0, `rd_valid_o`=0, flags 0.
- Write 0x0001..0x0005 to VC0, then 5 reads → `full_o[0]`=1 after the 5th write; reads return 0x0001..0x0005 in order with `rd_valid_o`=1; `empty_o[0]`=1 at the end; VC1 untouched.
- Wrap-around, DEPTH=5: 7 writes interleaved with reads (2 writes, 1 read, repeated) → data order preserved across the pointer wrap from 4 to 0; count trajectory matches the model.
- 6th write to full VC0 (0xBEEF) → dropped, `overflow_o[0]`=1, next 5 reads contain no 0xBEEF. Read of empty VC1 → `underflow_o[1]`=1, `rd_valid_o`=0.
- Same-cycle write and read: on empty VC1, read rejected and count becomes 1. On full VC0, write rejected and count becomes 4. On VC0 with count 2, count stays 2.
- Drive `reset` low mid-stream with VC0 count 3 and a concurrent write → all outputs at reset values next cycle, and the write is discarded.
